// File: rtl/motor_dir_ctrl.sv
// Multi-channel H-bridge direction controller with enforced coast dead time.
// Optional MOTOR_DIR_PWM_EN adds a per-channel pwm input gating EN in CW/CCW.
module motor_dir_ctrl #(
  parameter int CHANNELS    = 2,
  parameter int DEAD_CYCLES = 12000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     select_direction,
  input  logic [CHANNELS-1:0]     brake,
`ifdef MOTOR_DIR_PWM_EN
  input  logic [CHANNELS-1:0]     pwm,
`endif
  output logic [2*CHANNELS-1:0]   motor_driver_inputs,
  output logic [CHANNELS-1:0]     enable,
  output logic [CHANNELS-1:0]     busy
);

  typedef enum logic [1:0] {
    S_COAST = 2'd0,
    S_CW    = 2'd1,
    S_CCW   = 2'd2,
    S_BRAKE = 2'd3
  } state_e;

  localparam int CNT_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYCLES - 1);

  genvar k;
  generate
    for (k = 0; k < CHANNELS; k++) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             drive_en;
      logic [1:0]       pins;
      logic             en;
      logic             bsy;

      always_comb begin
        state_d = state_q;
        unique case (state_q)
          S_CW:    if (select_direction[k]) state_d = S_COAST;
          S_CCW:   if (!select_direction[k]) state_d = S_COAST;
          S_COAST: if (cnt_q == CNT_LAST)
                     state_d = select_direction[k] ? S_CCW : S_CW;
          S_BRAKE: state_d = S_COAST;
          default: state_d = S_COAST;
        endcase
        if (brake[k]) state_d = S_BRAKE;
        // Counter reloads on every entry into coast, so each coast is full.
        cnt_d = '0;
        if (state_q == S_COAST && state_d == S_COAST)
          cnt_d = cnt_q + CNT_W'(1);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          state_q <= S_COAST;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

`ifdef MOTOR_DIR_PWM_EN
      logic pwm_q, pwm_d;

      always_comb begin
        pwm_d = pwm[k];
      end

      always_ff @(posedge clk) begin
        if (reset) pwm_q <= 1'b0;
        else       pwm_q <= pwm_d;
      end

      assign drive_en = pwm_q;
`else
      assign drive_en = 1'b1;
`endif

      always_comb begin
        pins = 2'b00;
        en   = 1'b0;
        bsy  = 1'b0;
        unique case (state_q)
          S_CW:    begin pins = 2'b10; en = drive_en; end
          S_CCW:   begin pins = 2'b01; en = drive_en; end
          S_BRAKE: begin pins = 2'b11; en = 1'b1;     end
          default: begin pins = 2'b00; bsy = 1'b1;    end
        endcase
      end

      assign motor_driver_inputs[2*k +: 2] = pins;
      assign enable[k]                     = en;
      assign busy[k]                       = bsy;
    end
  endgenerate

endmodule

// File: doc/motor_dir_ctrl.md
# motor_dir_ctrl

Multi-channel H-bridge direction controller for SN754410-class drivers. It converts per-channel direction and brake requests into A1/A2 and EN pin levels. Every change of drive polarity passes through an enforced coast (dead-time) interval, so a motor is never reversed while it is spinning under power. It sits between the Nios-facing control registers and the motor driver pins, and replaces the single-channel combinational direction decode.

## Interface
- `CHANNELS`, default 2: number of independent motor channels, 1..8.
- `DEAD_CYCLES`, default 12000: coast duration in clk cycles (1 ms at 12 MHz); must be at least 1.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: synchronous, active-high.
- `select_direction` input, CHANNELS bits: per channel, 0 = clockwise, 1 = counter-clockwise.
- `brake` input, CHANNELS bits: per channel, 1 = dynamic brake request.
- `pwm` input, CHANNELS bits: present only with `MOTOR_DIR_PWM_EN`; per-channel speed PWM.
- `motor_driver_inputs` output, 2*CHANNELS bits: bits [2k+1:2k] drive channel k as {A2, A1}.
- `enable` output, CHANNELS bits: per-channel driver EN pin.
- `busy` output, CHANNELS bits: 1 while the channel is in COAST.

## Operation
- Each channel has its own state machine and dead-time counter, fully independent of the other channels.
- States and their pin levels ({A2,A1}, EN):
  - CW: 2'b10, EN 1.
  - CCW: 2'b01, EN 1.
  - COAST: 2'b00, EN 0.
  - BRAKE: 2'b11, EN 1.
- Brake has the highest priority. While `brake` is 1, any state goes to BRAKE on the next edge.
- BRAKE to COAST: taken when `brake` is 0. Releasing the brake always passes through a full coast.
- CW to COAST: taken when `select_direction` is 1. CCW to COAST: taken when `select_direction` is 0.
- COAST to CW or CCW: taken when the counter reaches DEAD_CYCLES-1.
  - The target is set by `select_direction` sampled on that final edge; 0 gives CW, 1 gives CCW.
  - Direction toggles during COAST do not restart the counter. Only the final sample matters.
- Counter:
  - Width is $clog2(DEAD_CYCLES+1).
  - Loads 0 on entry to COAST and increments once per cycle in COAST.
  - Holds 0 in all other states.
- `busy[k]` is 1 exactly when channel k is in COAST.
- Reset: all channels go to COAST with counter 0.
  - Reset output values: `motor_driver_inputs` = all 0, `enable` = all 0, `busy` = all 1.
  - After reset is released, each channel drives according to `select_direction` once DEAD_CYCLES cycles have passed.
- Reset asserted mid-COAST or mid-drive: same behaviour; the coast restarts from counter 0.

## Timing
- All outputs are registered, decoded from the state register only; there is no combinational path from inputs to outputs.
- Inputs are sampled on the rising edge of clk. A request sampled on edge N is visible on the pins after edge N.
- Reversal sequence, with the reversing select sampled at edge N:
  - Pins show COAST for exactly DEAD_CYCLES cycles, from edge N through edge N+DEAD_CYCLES.
  - The new direction appears after edge N+DEAD_CYCLES.
- Brake response is one cycle from any state, including mid-COAST.
- Brake held for one cycle only: BRAKE for 1 cycle, then a full COAST.
- Brake and a direction change on the same edge: brake wins.
- Asynchronous external inputs must be synchronised upstream; this block assumes synchronous inputs.

## Configuration
- `MOTOR_DIR_PWM_EN` defined:
  - The `pwm` port exists.
  - In CW and CCW, `enable[k]` = `pwm[k]`, registered.
  - COAST forces EN to 0 and BRAKE forces EN to 1, whatever the value of `pwm`.
- `MOTOR_DIR_PWM_EN` not defined:
  - The `pwm` port is absent.
  - EN is constant 1 in CW and CCW.
  - All other behaviour is identical.

## Test plan
All scenarios use CHANNELS=2 and DEAD_CYCLES=4.
- Reset, then release with select=2'b00 and brake=0. Required: pins 4'b0000 and busy=2'b11 for 4 cycles, then pins 4'b1010, enable=2'b11, busy=2'b00.
- Channel 0 in CW; set select[0]=1 at edge N. Required: channel 0 pins 00 and EN 0 from edge N through N+4, then 01 with EN 1. Channel 1 is unchanged throughout.
- Channel 0 in COAST; toggle select[0] 1→0→1 over 3 cycles. Required: coast length is still 4 cycles, and the channel ends in CCW (01).
- Channel 1 in CCW; pulse brake[1] for 1 cycle. Required: channel 1 pins 11 with EN 1 for 1 cycle, then 00 for 4 cycles, then 01.
- Assert reset for one cycle midway through a coast. Required: outputs 0, busy=2'b11, and a fresh 4-cycle coast begins after release.
- With `MOTOR_DIR_PWM_EN` defined, channel 0 in CW, drive pwm[0] with a 50% square wave. Required: enable[0] follows pwm[0] one cycle later; during COAST enable[0] stays 0; during BRAKE it stays 1.
